halflife_sequencer: RTL
=======================

# halflife_sequencer

Sequencing controller for the half-life counter datapath. Loads an initial activity value, then halves it once per programmable half-life period until it reaches zero. Counts the elapsed half-lives and signals completion with a one-cycle pulse. Sits between the top-level I/O and the display/readout logic, and replaces manual up/down/load strobing of the counter.

## Interface
Parameters:
- `n`, 4, activity count width in bits
- `p`, 8, half-life period width in bits
- `hw`, `$clog2(n+1)`, half-life counter width (localparam, derived)

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous reset, active-low; the block is in reset while `rst`=0
- `start`  input  1  begin a decay run; honoured only when not busy
- `abort`  input  1  terminate a run in progress
- `load_val`  input  n  initial activity, sampled on an accepted `start`
- `period`  input  p  half-life in clock cycles, sampled on an accepted `start`
- `count`  output  n  current activity
- `halvings`  output  hw  number of half-lives elapsed in the current or last run
- `busy`  output  1  run in progress (state RUN)
- `done`  output  1  one-cycle pulse when activity reaches zero

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `count`=0, `halvings`=0, `busy`=0, `done`=0, internal timer=0, period register=0.
- IDLE, `start`=1:
  - Latch `count`←`load_val`, `halvings`←0, timer←0, period register←`period`.
  - If `period`=0, it is treated as 1.
  - If `load_val`≠0, go to RUN. If `load_val`=0, go to DONE directly.
- RUN:
  - The timer increments every cycle.
  - When timer = period register − 1: timer←0, `count`←`count`>>1 (logical shift, floor), `halvings`←`halvings`+1.
  - If the halved value is 0, go to DONE; otherwise stay in RUN.
  - `halvings` never exceeds n, so no saturation logic is needed.
- RUN, `abort`=1: go to IDLE on the next edge. No `done` pulse. `count` and `halvings` hold their current values. `abort` has priority over a halving tick in the same cycle, so the tick is discarded.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then unconditionally go to IDLE. `start` is ignored in DONE.
- IDLE holds `count` and `halvings` from the last run until the next accepted `start`.
- `start` while busy is ignored. `abort` outside RUN is ignored.
- `load_val` and `period` changes during a run have no effect.

## Timing
- Accepted `start` at edge E0: the new `count` and `busy`=1 are visible after E0.
- Halving edges occur at E0+k·T, where T = max(period,1).
- Number of halvings to reach zero = floor(log2(load_val))+1.
- `done` is high for the cycle following the final halving edge. `busy` falls at that same edge.
- `load_val`=0: `done` is high for the cycle after E0, with `halvings`=0.
- Earliest accepted restart: the cycle after DONE, in IDLE.
- Async reset mid-run: all outputs clear immediately, the block goes to IDLE, and no `done` pulse is produced.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- Macro `HALFLIFE_IRQ_EN`.
- When defined:
  - Adds input `irq_clr` (1 bit) and output `irq` (1 bit, reset 0).
  - `irq` sets on the `done` pulse and stays set until `irq_clr`=1.
  - If set and clear occur in the same cycle, set wins.
- When undefined: neither port exists, and behaviour is otherwise identical.

## Structure
- Package `halflife_pkg` contains:
  - `state_t` enum (IDLE, RUN, DONE).
  - Default width constants for `n` and `p`.
- Sub-module `halflife_tick` is the period timer:
  - Inputs: `clk`, `rst`, `clr`, `en`, `period`.
  - Output: `tick`, a single-cycle pulse every T cycles while `en` is high.
  - The FSM, shifter and half-life counter stay in `halflife_sequencer`.

## Test plan
- Reset mid-run:
  - Stimulus: `load_val`=8, `period`=3; assert `rst`=0 at E5.
  - Response: all outputs read 0 immediately. State is IDLE, `done` never pulses.
- Nominal run:
  - Stimulus: `load_val`=8, `period`=3, `start` at E0.
  - Response: `count` reads 4, 2, 1, 0 after E3, E6, E9, E12. `done` is high only in the cycle after E12. `halvings`=4. `busy` is high from E0 to E12.
- Zero period and odd value:
  - Stimulus: `load_val`=13, `period`=0.
  - Response: `count` reads 6, 3, 1, 0 on consecutive edges, then `done` pulses with `halvings`=4.
- Zero load:
  - Stimulus: `load_val`=0, `start`.
  - Response: `done` pulse one cycle after `start`, `halvings`=0, `busy` never high.
- Abort and ignored start:
  - Stimulus: `load_val`=15, `period`=4. Pulse `start` again during RUN (ignored). Assert `abort` at E8, coincident with a tick.
  - Response: IDLE after E8, `count`=7, `halvings`=1, no `done` pulse.
- IRQ (with `HALFLIFE_IRQ_EN`):
  - Stimulus: complete a run, then hold `irq_clr` during the `done` cycle, then pulse `irq_clr` one cycle later.
  - Response: `irq` sets (set wins over the coincident clear), then clears one cycle after the later `irq_clr`.

Source files
------------

// File: rtl/halflife_pkg.sv
`default_nettype none
// ============================================================================
// Module   : halflife_pkg
// Purpose  : Shared types and default widths for the half-life sequencer
//            slice (FSM state encoding, default activity/period widths).
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package halflife_pkg;

    // Default activity count width and half-life period width
    localparam int c_n_default = 4;
    localparam int c_p_default = 8;

    // Sequencer states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : halflife_pkg
`default_nettype wire

// File: rtl/halflife_tick.sv
`default_nettype none
// ============================================================================
// Module   : halflife_tick
// Purpose  : Half-life period timer. Emits a single-cycle tick every
//            'period' cycles while enabled; cleared timer restarts from 0.
// Ports    : clk     - rising-edge clock
//            rst     - asynchronous reset, active-low
//            clr     - synchronous timer clear (takes priority over en)
//            en      - advance the timer this cycle
//            period  - half-life length in cycles (caller guarantees >= 1)
//            tick    - high in the cycle whose closing edge ends a period
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module halflife_tick
    import halflife_pkg::*;
#(
    parameter int p = c_p_default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [p-1:0] period,
    output logic         tick
);

    logic [p-1:0] r_timer;
    logic [p-1:0] w_last;

    // Last timer value of a period; period is never 0 here, so no wrap
    assign w_last = period - p'(1);
    assign tick   = en && (r_timer == w_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (clr) begin
            r_timer <= '0;
        end else if (en) begin
            r_timer <= tick ? '0 : (r_timer + p'(1));
        end
    end

endmodule : halflife_tick
`default_nettype wire

// File: rtl/halflife_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : halflife_sequencer
// Purpose  : Loads an initial activity, halves it once per programmable
//            half-life period until zero, counts the halvings and pulses
//            'done' for one cycle at completion. All outputs registered.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous reset, active-low
//            start     - begin a run (honoured in IDLE only)
//            abort     - end a run in progress (honoured in RUN only)
//            load_val  - initial activity, sampled on accepted start
//            period    - half-life in cycles (0 treated as 1), sampled on start
//            count     - current activity
//            halvings  - half-lives elapsed in current/last run
//            busy      - run in progress
//            done      - one-cycle completion pulse
//            irq_clr   - (HALFLIFE_IRQ_EN only) clear sticky interrupt
//            irq       - (HALFLIFE_IRQ_EN only) sticky completion interrupt
// Config   : HALFLIFE_IRQ_EN - adds the sticky completion interrupt
// Revision : 1.0 - initial release
// ============================================================================
module halflife_sequencer
    import halflife_pkg::*;
#(
    parameter  int n  = c_n_default,
    parameter  int p  = c_p_default,
    localparam int hw = $clog2(n + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [n-1:0]  load_val,
    input  logic [p-1:0]  period,
    output logic [n-1:0]  count,
    output logic [hw-1:0] halvings,
    output logic          busy,
    output logic          done
`ifdef HALFLIFE_IRQ_EN
    ,
    input  logic          irq_clr,
    output logic          irq
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [n-1:0]  r_count;
    logic [hw-1:0] r_halvings;
    logic [p-1:0]  r_period;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_tick_en;
    logic          w_tick_clr;
    logic          w_tick;
    logic [n-1:0]  w_half;

    assign w_accept   = (r_state == IDLE) && start;
    // Abort gates the timer so a coincident tick is discarded outright
    assign w_tick_en  = (r_state == RUN) && !abort;
    // Timer is held at zero outside RUN so each run starts a fresh period
    assign w_tick_clr = (r_state != RUN);
    assign w_half     = {1'b0, r_count[n-1:1]};

    halflife_tick #(
        .p      (p)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_tick_clr),
        .en     (w_tick_en),
        .period (r_period),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_tick && (w_half == '0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_halvings <= '0;
            r_period   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Status flags track the next state so they are registered
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_count    <= load_val;
                r_halvings <= '0;
                r_period   <= (period == '0) ? p'(1) : period;
            end else if (w_tick) begin
                r_count    <= w_half;
                r_halvings <= r_halvings + hw'(1);
            end
        end
    end

    assign count    = r_count;
    assign halvings = r_halvings;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef HALFLIFE_IRQ_EN
    logic r_irq;

    // Set has priority over a coincident clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if (r_done) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    // No interrupt logic in this build
`endif

endmodule : halflife_sequencer
`default_nettype wire
